// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and constants for the maze path replay block
package maze_pkg;

    localparam int CW_DEF    = 4;
    localparam int DEPTH_DEF = 169;
    localparam int AW_DEF    = 8;
    localparam int START_XY  = 1;
    localparam int GOAL_XY   = 13;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPLAY  = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

endpackage

// File: rtl/maze_path_replay_if.sv
// rtl/maze_path_replay_if.sv - solver path input and replay output bundle
interface maze_path_replay_if #(
    parameter int CW = 4,
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_not_valid;
    logic [CW-1:0] in_x;
    logic [CW-1:0] in_y;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic [1:0]    out_dir;
    logic          out_first;
    logic          out_last;
    logic          out_fail;
    logic [AW-1:0] path_len;
    logic          busy;

    modport master (
        output in_valid, in_not_valid, in_x, in_y, out_ready,
        input  out_valid, out_x, out_y, out_dir, out_first, out_last, out_fail, path_len, busy
    );

    modport slave (
        input  in_valid, in_not_valid, in_x, in_y, out_ready,
        output out_valid, out_x, out_y, out_dir, out_first, out_last, out_fail, path_len, busy
    );
endinterface

// File: rtl/path_lifo.sv
// rtl/path_lifo.sv - flop stack holding captured path cells, combinational top read
module path_lifo #(
    parameter int W     = 8,
    parameter int DEPTH = 169,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] top_idx;

    assign full    = (count == AW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = count - AW'(1);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + AW'(1);
        end else if (pop && !empty) begin
            count <= count - AW'(1);
        end
    end

    // Storage is left unreset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[count] <= din;
        end
    end
endmodule

// File: rtl/maze_path_replay.sv
// rtl/maze_path_replay.sv - LIFO replay of solver path start->goal; MAZE_PATH_ADJ_CHECK_EN adds step check
module maze_path_replay
    import maze_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    maze_path_replay_if.slave bus
);
    state_t          state, state_nx;
    logic            err_q, err_d;
    logic            ov_q, ov_d;
    logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
    dir_t            odir_q, odir_d;
    logic            ofirst_q, ofirst_d, olast_q, olast_d, ofail_q, ofail_d;
    logic [AW-1:0]   plen_q, plen_d;
    logic            busy_q, busy_d;

    logic            push, pop, clear, adj_err;
    logic [2*CW-1:0] lifo_top;
    logic [AW-1:0]   lifo_count;
    logic            lifo_full, lifo_empty;
    logic [CW-1:0]   top_x, top_y;

    assign top_x = lifo_top[2*CW-1:CW];
    assign top_y = lifo_top[CW-1:0];

    function automatic dir_t step_dir(input logic [CW-1:0] px, py, cx, cy);
        if (cx > px) return DIR_RIGHT;
        if (cx < px) return DIR_LEFT;
        if (cy < py) return DIR_UP;
        if (cy > py) return DIR_DOWN;
        return DIR_RIGHT;
    endfunction

    path_lifo #(.W(2*CW), .DEPTH(DEPTH), .AW(AW)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   ({bus.in_x, bus.in_y}),
        .top   (lifo_top),
        .count (lifo_count),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

`ifdef MAZE_PATH_ADJ_CHECK_EN
    logic [CW-1:0] last_x, last_y, dx_abs, dy_abs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_x <= '0;
            last_y <= '0;
        end else if (push) begin
            last_x <= bus.in_x;
            last_y <= bus.in_y;
        end
    end

    always_comb begin
        dx_abs  = (bus.in_x > last_x) ? bus.in_x - last_x : last_x - bus.in_x;
        dy_abs  = (bus.in_y > last_y) ? bus.in_y - last_y : last_y - bus.in_y;
        adj_err = !(((dx_abs == CW'(1)) && (dy_abs == '0)) ||
                    ((dx_abs == '0) && (dy_abs == CW'(1))));
    end
`else
    assign adj_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            err_q    <= 1'b0;
            ov_q     <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            odir_q   <= DIR_RIGHT;
            ofirst_q <= 1'b0;
            olast_q  <= 1'b0;
            ofail_q  <= 1'b0;
            plen_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            err_q    <= err_d;
            ov_q     <= ov_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            odir_q   <= odir_d;
            ofirst_q <= ofirst_d;
            olast_q  <= olast_d;
            ofail_q  <= ofail_d;
            plen_q   <= plen_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.in_valid) state_nx = bus.in_not_valid ? ST_FAIL : ST_COLLECT;
            ST_COLLECT: if (!bus.in_valid) state_nx = (err_q || lifo_empty) ? ST_FAIL : ST_REPLAY;
            ST_REPLAY:  if (ov_q && bus.out_ready && olast_q) state_nx = ST_IDLE;
            ST_FAIL:    if (bus.out_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // The output register always holds an entry already popped, so the LIFO top is the next beat.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        clear    = 1'b0;
        err_d    = err_q;
        ov_d     = ov_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        odir_d   = odir_q;
        ofirst_d = ofirst_q;
        olast_d  = olast_q;
        ofail_d  = ofail_q;
        plen_d   = plen_q;
        busy_d   = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (bus.in_valid && !bus.in_not_valid) begin
                    push   = 1'b1;
                    err_d  = 1'b0;
                    plen_d = AW'(1);
                end else if (bus.in_valid) begin
                    ov_d = 1'b1; ofail_d = 1'b1; olast_d = 1'b1; ofirst_d = 1'b0;
                    ox_d = '0; oy_d = '0; odir_d = DIR_RIGHT;
                end
            end
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    if (bus.in_not_valid || lifo_full) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (adj_err) err_d = 1'b1;
                    end
                    if (!bus.in_not_valid && plen_q != AW'(DEPTH)) plen_d = plen_q + AW'(1);
                end else if (err_q || lifo_empty) begin
                    ov_d = 1'b1; ofail_d = 1'b1; olast_d = 1'b1; ofirst_d = 1'b0;
                    ox_d = '0; oy_d = '0; odir_d = DIR_RIGHT;
                end else begin
                    pop = 1'b1;
                    ov_d = 1'b1; ofail_d = 1'b0; ofirst_d = 1'b1;
                    olast_d = (lifo_count == AW'(1));
                    ox_d = top_x; oy_d = top_y; odir_d = DIR_RIGHT;
                end
            end
            ST_REPLAY: begin
                if (ov_q && bus.out_ready) begin
                    if (olast_q) begin
                        ov_d = 1'b0; ofirst_d = 1'b0; olast_d = 1'b0;
                        ox_d = '0; oy_d = '0; odir_d = DIR_RIGHT;
                    end else begin
                        pop = 1'b1;
                        ofirst_d = 1'b0;
                        olast_d  = (lifo_count == AW'(1));
                        ox_d = top_x; oy_d = top_y;
                        odir_d = step_dir(ox_q, oy_q, top_x, top_y);
                    end
                end
            end
            ST_FAIL: begin
                if (bus.out_ready) begin
                    clear = 1'b1;
                    err_d = 1'b0;
                    ov_d = 1'b0; ofail_d = 1'b0; olast_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.out_valid = ov_q;
    assign bus.out_x     = ox_q;
    assign bus.out_y     = oy_q;
    assign bus.out_dir   = odir_q;
    assign bus.out_first = ofirst_q;
    assign bus.out_last  = olast_q;
    assign bus.out_fail  = ofail_q;
    assign bus.path_len  = plen_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_maze_path_replay.sv
// tb/tb_maze_path_replay.sv - directed bench with queue model of start->goal replay
module tb_maze_path_replay;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] dir;
        logic       first;
        logic       last;
        logic       fail;
    } beat_t;

    localparam int DEPTH = 169;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cell_t cells[$];
    beat_t exp_q[$];
    beat_t seen_q[$];
    beat_t prev_beat;
    bit    stalled = 0;
    logic [3:0] pat = 4'b1001;

    always #5 clk = ~clk;

    maze_path_replay_if #(.CW(4), .AW(8)) bus ();

    maze_path_replay dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] dir_of(input cell_t p, input cell_t c);
        int dx, dy;
        dx = int'(c.x) - int'(p.x);
        dy = int'(c.y) - int'(p.y);
        if (dx > 0) return 2'd0;
        if (dx < 0) return 2'd2;
        if (dy < 0) return 2'd1;
        if (dy > 0) return 2'd3;
        return 2'd0;
    endfunction

    // Solver pushes goal->start; replay is that list reversed.
    task automatic build_expected();
        int    n;
        bit    fail;
        cell_t c, p;
        beat_t b;
        n = cells.size();
        fail = (n > DEPTH);
`ifdef MAZE_PATH_ADJ_CHECK_EN
        for (int i = 1; i < n; i++) begin
            int dx, dy;
            dx = int'(cells[i].x) - int'(cells[i-1].x);
            dy = int'(cells[i].y) - int'(cells[i-1].y);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (dx + dy != 1) fail = 1;
        end
`endif
        if (fail) begin
            b = '{x: 4'd0, y: 4'd0, dir: 2'd0, first: 1'b0, last: 1'b1, fail: 1'b1};
            exp_q.push_back(b);
        end else begin
            p = '0;
            for (int k = 0; k < n; k++) begin
                c = cells[n-1-k];
                b.x = c.x;
                b.y = c.y;
                b.dir = (k == 0) ? 2'd0 : dir_of(p, c);
                b.first = (k == 0);
                b.last = (k == n - 1);
                b.fail = 1'b0;
                exp_q.push_back(b);
                p = c;
            end
        end
    endtask

    task automatic add_cell(input int x, input int y);
        cell_t c;
        c.x = 4'(x);
        c.y = 4'(y);
        cells.push_back(c);
    endtask

    task automatic run_path();
        build_expected();
        seen_q.delete();
        foreach (cells[i]) begin
            bus.in_valid = 1'b1;
            bus.in_not_valid = 1'b0;
            bus.in_x = cells[i].x;
            bus.in_y = cells[i].y;
            @(posedge clk) #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 800; i++) begin
            if (exp_q.size() == 0 && !bus.busy) begin
                done = 1;
                break;
            end
            bus.out_ready = toggle ? pat[i % 4] : 1'b1;
            @(posedge clk) #1;
        end
        chk(name, 32'(done), 32'd1);
        bus.out_ready = 1'b1;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {bus.out_valid, bus.out_x, bus.out_y, bus.out_dir, bus.out_first,
                   bus.out_last, bus.out_fail, bus.path_len, bus.busy}, 32'd0);
    endtask

    // Every displayed beat is checked against the model head; stalled beats must hold.
    always @(negedge clk) begin
        beat_t cur;
        if (!rst_n) begin
            stalled = 0;
        end else if (bus.out_valid) begin
            cur = {bus.out_x, bus.out_y, bus.out_dir, bus.out_first, bus.out_last, bus.out_fail};
            if (stalled) chk("stall_stable", 32'(cur), 32'(prev_beat));
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat actual=%0h required=none", cur);
            end else begin
                chk("beat", 32'(cur), 32'(exp_q[0]));
            end
            if (bus.out_ready) begin
                seen_q.push_back(cur);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                stalled = 0;
            end else begin
                stalled = 1;
                prev_beat = cur;
            end
        end else begin
            stalled = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        cell_t sg[$];
        bit    hit;
        bus.in_valid = 1'b0;
        bus.in_not_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk) #1;

        // straight path
        cells.delete();
        add_cell(3, 1); add_cell(2, 1); add_cell(1, 1);
        run_path();
        drain(0, "straight_drain");
        chk("straight_count", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            chk("straight_b0", 32'(seen_q[0]), 32'(13'b0001_0001_00_100));
            chk("straight_b1", 32'(seen_q[1]), 32'(13'b0010_0001_00_000));
            chk("straight_b2", 32'(seen_q[2]), 32'(13'b0011_0001_00_010));
        end
        chk("straight_len", 32'(bus.path_len), 32'd3);
        chk("straight_idle", 32'(bus.busy), 32'd0);

        // maze not valid with backpressure
        seen_q.delete();
        exp_q.push_back('{x: 4'd0, y: 4'd0, dir: 2'd0, first: 1'b0, last: 1'b1, fail: 1'b1});
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_not_valid = 1'b1;
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        bus.in_not_valid = 1'b0;
        chk("fail_beat", {bus.out_valid, bus.out_fail, bus.out_last, bus.out_x, bus.out_y}, 32'h700);
        repeat (4) @(posedge clk);
        #1;
        chk("fail_held", {bus.out_valid, bus.out_fail, bus.busy}, 32'h7);
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        chk("fail_accept", {bus.out_valid, bus.busy}, 32'h0);
        chk("fail_count", 32'(seen_q.size()), 32'd1);

        // full 169-cell snake, start (1,1) to goal (13,13)
        sg.delete();
        for (int y = 1; y <= 13; y++)
            for (int k = 0; k < 13; k++)
                sg.push_back('{x: 4'((y % 2 == 1) ? 1 + k : 13 - k), y: 4'(y)});
        cells.delete();
        for (int i = 168; i >= 0; i--) cells.push_back(sg[i]);
        run_path();
        drain(0, "snake_drain");
        chk("snake_count", 32'(seen_q.size()), 32'd169);
        if (seen_q.size() == 169)
            chk("snake_goal", 32'(seen_q[168]), 32'(13'b1101_1101_00_010));
        chk("snake_len", 32'(bus.path_len), 32'd169);

        // overflow: 170 pushes
        add_cell(1, 2);
        run_path();
        drain(0, "ovf_drain");
        chk("ovf_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() == 1) chk("ovf_fail", 32'(seen_q[0].fail), 32'd1);
        chk("ovf_len", 32'(bus.path_len), 32'd169);

        // backpressure on 5-cell path
        cells.delete();
        add_cell(3, 3); add_cell(3, 2); add_cell(2, 2); add_cell(2, 1); add_cell(1, 1);
        run_path();
        drain(1, "bp_drain");
        chk("bp_count", 32'(seen_q.size()), 32'd5);
        if (seen_q.size() == 5) chk("bp_down", 32'(seen_q[2].dir), 32'd3);

        // reset mid-replay after two beats
        run_path();
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk) #1;
            if (seen_q.size() >= 2) begin
                hit = 1;
                break;
            end
        end
        chk("rst_two_beats", 32'(hit), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk) #1;
        chk_zero("mid_reset");
        rst_n = 1'b1;
        cells.delete();
        add_cell(3, 1); add_cell(2, 1); add_cell(1, 1);
        run_path();
        drain(0, "post_rst_drain");
        chk("post_rst_count", 32'(seen_q.size()), 32'd3);

        // single-cell path
        cells.delete();
        add_cell(1, 1);
        run_path();
        drain(0, "single_drain");
        chk("single_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() == 1) chk("single_beat", 32'(seen_q[0]), 32'(13'b0001_0001_00_110));

        // non-adjacent step
        cells.delete();
        add_cell(3, 3); add_cell(1, 1);
        run_path();
        drain(0, "nonadj_drain");
`ifdef MAZE_PATH_ADJ_CHECK_EN
        chk("nonadj_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() == 1) chk("nonadj_fail", 32'(seen_q[0].fail), 32'd1);
`else
        chk("nonadj_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) chk("nonadj_b1", 32'(seen_q[1]), 32'(13'b0011_0011_00_010));
`endif

        chk("model_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
